fir_coeff_loader: RTL

FIR_COEFF_LOADER -- requirements
Module: fir_coeff_loader

---
 rtl/fir_coeff_loader.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/fir_coeff_loader.sv
// fir_coeff_loader: accepts a frame of NUM_TAPS coefficient words over a
// valid/ready stream into a shadow bank. Once the frame is complete, the
// bank is committed atomically to packed_coeffs. A one-cycle coeff_update
// pulse marks the first cycle in which the new bank is visible.
//
// Optional build macro FIR_COEFF_CHECKSUM_EN adds a CHECK state. In that
// build the frame carries one extra word, and the frame commits only if
// that word plus the modular sum of the coefficients is zero. A failed
// check sets the sticky error flag and leaves the bank untouched.
module fir_coeff_loader #(
    parameter int NUM_TAPS    = 4,
    parameter int COEFF_WIDTH = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic                            abort,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [COEFF_WIDTH-1:0]          s_data,
    output logic [COEFF_WIDTH*NUM_TAPS-1:0] packed_coeffs,
    output logic                            coeff_update,
    output logic                            busy,
    output logic                            error
);

    localparam int IDX_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TAPS - 1);

`ifdef FIR_COEFF_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, LOAD, CHECK, COMMIT} state_e;
`else
    typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_e;
`endif

    state_e                            state_q, state_d;
    logic [IDX_W-1:0]                  index_q, index_d;
    logic [COEFF_WIDTH-1:0]            shadow_q [NUM_TAPS];
    logic [COEFF_WIDTH-1:0]            shadow_d [NUM_TAPS];
    logic [COEFF_WIDTH*NUM_TAPS-1:0]   packed_q, packed_d;
    logic                              coeff_update_q, coeff_update_d;
    logic                              xfer;

`ifdef FIR_COEFF_CHECKSUM_EN
    logic [COEFF_WIDTH-1:0]            sum_q, sum_d;
    logic [COEFF_WIDTH-1:0]            check_sum;
    logic                              error_q, error_d;
`endif

    assign xfer = s_valid && s_ready;

    // State register: synchronous active-low reset returns the FSM to IDLE.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: the frame walks through LOAD (and CHECK) to COMMIT;
    // abort drops back to IDLE.
    // NOTE: each combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = LOAD;
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (xfer && index_q == LAST_IDX) begin
`ifdef FIR_COEFF_CHECKSUM_EN
                    state_d = CHECK;
`else
                    state_d = COMMIT;
`endif
                end
            end
`ifdef FIR_COEFF_CHECKSUM_EN
            CHECK: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (xfer) begin
                    state_d = (check_sum == '0) ? COMMIT : IDLE;
                end
            end
`endif
            COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode: words are accepted only while loading and not aborting.
    always_comb begin
`ifdef FIR_COEFF_CHECKSUM_EN
        s_ready = (state_q == LOAD || state_q == CHECK) && !abort;
`else
        s_ready = (state_q == LOAD) && !abort;
`endif
        busy = (state_q != IDLE);
    end

`ifdef FIR_COEFF_CHECKSUM_EN
    // Checksum candidate: the incoming word added to the running sum, modulo 2^COEFF_WIDTH.
    always_comb begin
        check_sum = sum_q + s_data;
    end
`endif

    // Datapath next values: fill the shadow bank, then copy it into the live bank on commit.
    always_comb begin
        index_d        = index_q;
        shadow_d       = shadow_q;
        packed_d       = packed_q;
        coeff_update_d = 1'b0;
`ifdef FIR_COEFF_CHECKSUM_EN
        sum_d          = sum_q;
        error_d        = error_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    index_d = '0;
`ifdef FIR_COEFF_CHECKSUM_EN
                    sum_d   = '0;
                    error_d = 1'b0;
`endif
                end
            end
            LOAD: begin
                if (xfer) begin
                    shadow_d[index_q] = s_data;
                    index_d = (index_q == LAST_IDX) ? '0 : index_q + IDX_W'(1);
`ifdef FIR_COEFF_CHECKSUM_EN
                    sum_d = check_sum;
`endif
                end
            end
`ifdef FIR_COEFF_CHECKSUM_EN
            CHECK: begin
                if (xfer && check_sum != '0) error_d = 1'b1;
            end
`endif
            COMMIT: begin
                for (int k = 0; k < NUM_TAPS; k++) begin
                    packed_d[COEFF_WIDTH*k +: COEFF_WIDTH] = shadow_q[k];
                end
                coeff_update_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Datapath registers: a reset mid-frame discards everything, including the shadow bank.
    // NOTE: the shadow storage is reset too, so a bank never exposes stale data after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            index_q        <= '0;
            packed_q       <= '0;
            coeff_update_q <= 1'b0;
            for (int k = 0; k < NUM_TAPS; k++) shadow_q[k] <= '0;
`ifdef FIR_COEFF_CHECKSUM_EN
            sum_q          <= '0;
            error_q        <= 1'b0;
`endif
        end else begin
            index_q        <= index_d;
            packed_q       <= packed_d;
            coeff_update_q <= coeff_update_d;
            shadow_q       <= shadow_d;
`ifdef FIR_COEFF_CHECKSUM_EN
            sum_q          <= sum_d;
            error_q        <= error_d;
`endif
        end
    end

    assign packed_coeffs = packed_q;
    assign coeff_update  = coeff_update_q;
`ifdef FIR_COEFF_CHECKSUM_EN
    assign error = error_q;
`else
    assign error = 1'b0;
`endif

endmodule
